// File: rtl/led7_scan_pkg.sv
// led7_scan_pkg: shared state encoding, digit width and sizing helper for the LED scan controller
package led7_scan_pkg;
  typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_e;
  localparam int DIGIT_W = 4;
  function automatic int clog2(input int n);
    int r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler: per-digit slot timer with slot start, blank end and slot end strobes
module scan_prescaler
  import led7_scan_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic clk,
  input  logic reset,
  output logic slot_start,
  output logic blank_end,
  output logic slot_end
);
  localparam int CW = clog2(SCAN_DIV);
  logic [CW-1:0] slot_cnt_q, slot_cnt_d;
  assign slot_start = slot_cnt_q == '0;
  assign blank_end  = slot_cnt_q == CW'(BLANK_CYCLES - 1);
  assign slot_end   = slot_cnt_q == CW'(SCAN_DIV - 1);
  // count 0..SCAN_DIV-1 and wrap
  always_comb begin
    slot_cnt_d = slot_end ? '0 : slot_cnt_q + 1'b1;
  end
  // slot counter register
  always_ff @(posedge clk) begin
    if (reset) slot_cnt_q <= '0;
    else       slot_cnt_q <= slot_cnt_d;
  end
endmodule

// File: rtl/led7_scan_ctrl.sv
// led7_scan_ctrl: multiplexes BCD digits onto a shared decoder with blanking, blink and decimal point
module led7_scan_ctrl
  import led7_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_FRAMES = 80
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]         blink_mask,
  input  logic [NUM_DIGITS-1:0]         dp_mask,
  input  logic                          display_on,
  output logic [DIGIT_W-1:0]            bcd_out,
  output logic                          dec_enable,
  output logic [NUM_DIGITS-1:0]         digit_sel,
  output logic                          dp_out,
  output logic                          frame_tick
);
  localparam int IW = clog2(NUM_DIGITS);
  localparam int BW = clog2(BLINK_FRAMES);
  logic slot_start, blank_end, slot_end, last_digit, blink_wrap, show;
  state_e state_q, state_d;
  logic [IW-1:0] digit_idx_q, digit_idx_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic blink_phase_q, blink_phase_d;
  logic [DIGIT_W-1:0] bcd_snap_q, bcd_snap_d;
  logic blink_snap_q, blink_snap_d, dp_snap_q, dp_snap_d;
  logic [DIGIT_W-1:0] bcd_out_q, bcd_out_d;
  logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
  logic dec_enable_q, dec_enable_d, dp_out_q, dp_out_d, frame_tick_q, frame_tick_d;

  scan_prescaler #(.SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK_CYCLES)) u_prescaler (
    .clk        (clk),
    .reset      (reset),
    .slot_start (slot_start),
    .blank_end  (blank_end),
    .slot_end   (slot_end)
  );

  assign last_digit = digit_idx_q == IW'(NUM_DIGITS - 1);
  assign blink_wrap = blink_cnt_q == BW'(BLINK_FRAMES - 1);

  // snapshot, scan index, blink timing, FSM and output decode; outputs follow the next state
  always_comb begin
    bcd_snap_d    = slot_start ? digits_in[DIGIT_W*int'(digit_idx_q) +: DIGIT_W] : bcd_snap_q;
    blink_snap_d  = slot_start ? blink_mask[digit_idx_q] : blink_snap_q;
    dp_snap_d     = slot_start ? dp_mask[digit_idx_q] : dp_snap_q;
    digit_idx_d   = slot_end ? (last_digit ? '0 : digit_idx_q + 1'b1) : digit_idx_q;
    frame_tick_d  = slot_end && last_digit;
    blink_cnt_d   = frame_tick_q ? (blink_wrap ? '0 : blink_cnt_q + 1'b1) : blink_cnt_q;
    blink_phase_d = blink_phase_q ^ (frame_tick_q && blink_wrap);
    state_d       = slot_end ? ST_BLANK : blank_end ? ST_SHOW : state_q;
    show          = state_d == ST_SHOW && display_on && !(blink_phase_q && blink_snap_d);
    bcd_out_d     = bcd_snap_d;
    digit_sel_d   = show ? ~(NUM_DIGITS'(1) << digit_idx_q) : '1;
    dec_enable_d  = show;
    dp_out_d      = show ? ~dp_snap_d : 1'b1;
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_BLANK;
      digit_idx_q   <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      bcd_snap_q    <= '0;
      blink_snap_q  <= 1'b0;
      dp_snap_q     <= 1'b0;
      bcd_out_q     <= '0;
      digit_sel_q   <= '1;
      dec_enable_q  <= 1'b0;
      dp_out_q      <= 1'b1;
      frame_tick_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      digit_idx_q   <= digit_idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      bcd_snap_q    <= bcd_snap_d;
      blink_snap_q  <= blink_snap_d;
      dp_snap_q     <= dp_snap_d;
      bcd_out_q     <= bcd_out_d;
      digit_sel_q   <= digit_sel_d;
      dec_enable_q  <= dec_enable_d;
      dp_out_q      <= dp_out_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign bcd_out    = bcd_out_q;
  assign dec_enable = dec_enable_q;
  assign digit_sel  = digit_sel_q;
  assign dp_out     = dp_out_q;
  assign frame_tick = frame_tick_q;
endmodule

// File: tb/tb_led7_scan_ctrl.sv
// tb_led7_scan_ctrl: directed self-checking bench for the LED scan controller
module tb_led7_scan_ctrl;
  logic clk, reset, display_on, dec_enable, dp_out, frame_tick;
  logic [15:0] digits_in;
  logic [3:0] blink_mask, dp_mask, bcd_out, digit_sel;
  int checks = 0;
  int errors = 0;

  led7_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2), .BLINK_FRAMES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .digits_in  (digits_in),
    .blink_mask (blink_mask),
    .dp_mask    (dp_mask),
    .display_on (display_on),
    .bcd_out    (bcd_out),
    .dec_enable (dec_enable),
    .digit_sel  (digit_sel),
    .dp_out     (dp_out),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_sel", digit_sel, 32'hF);
    chk("rst_dec", dec_enable, 0);
    chk("rst_bcd", bcd_out, 0);
    chk("rst_dp", dp_out, 1);
    chk("rst_ft", frame_tick, 0);
  endtask

  // Called at the falling edge inside cycle 0 of a slot; leaves at cycle 0 of the next slot.
  // act: 1 = switch digits_in to 9999 at cycle act_c, 2 = drop display_on for one cycle at act_c,
  // 3 = raise reset at act_c and return immediately.
  task automatic check_slot(input int f, input int d, input logic [3:0] v, input int act, input int act_c);
    logic dark_b, show, e_dp;
    logic [3:0] e_sel;
    string s;
    dark_b = blink_mask[d] && ((f / 2) % 2 == 1);
    for (int c = 0; c < 8; c++) begin
      s = $sformatf("f%0d d%0d c%0d", f, d, c);
      show = c >= 2 && !dark_b && !(act == 2 && c == act_c + 1);
      e_sel = show ? ~(4'b0001 << d) : 4'b1111;
      e_dp = show ? ~dp_mask[d] : 1'b1;
      chk({"sel ", s}, digit_sel, e_sel);
      chk({"dec ", s}, dec_enable, show);
      chk({"dp ", s}, dp_out, e_dp);
      chk({"ft ", s}, frame_tick, c == 0 && d == 0 && f > 0);
      if (c >= 1) chk({"bcd ", s}, bcd_out, v);
      if (c == act_c && act == 1) digits_in = 16'h9999;
      if (c == act_c && act == 2) display_on = 1'b0;
      if (c == act_c + 1 && act == 2) display_on = 1'b1;
      if (c == act_c && act == 3) begin
        reset = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    chk("onehot", $countones(~digit_sel) <= 1, 1);
    chk("dec_dark", dec_enable && digit_sel == 4'hF, 0);
  end

  initial begin
    reset = 1'b1;
    digits_in = 16'h4321;
    blink_mask = 4'b0100;
    dp_mask = 4'b0000;
    display_on = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset();
    reset = 1'b0;
    for (int f = 0; f < 10; f++)
      for (int d = 0; d < 4; d++) check_slot(f, d, 4'(d + 1), 0, 0);
    dp_mask = 4'b0010;
    check_slot(10, 0, 4'h1, 0, 0);
    check_slot(10, 1, 4'h2, 2, 4);
    check_slot(10, 2, 4'h3, 0, 0);
    check_slot(10, 3, 4'h4, 0, 0);
    for (int d = 0; d < 4; d++) check_slot(11, d, 4'(d + 1), 0, 0);
    check_slot(12, 0, 4'h1, 0, 0);
    check_slot(12, 1, 4'h2, 1, 5);
    check_slot(12, 2, 4'h9, 0, 0);
    check_slot(12, 3, 4'h9, 0, 0);
    check_slot(13, 0, 4'h9, 0, 0);
    check_slot(13, 1, 4'h9, 0, 0);
    check_slot(13, 2, 4'h9, 3, 4);
    @(negedge clk);
    chk_reset();
    reset = 1'b0;
    for (int d = 0; d < 4; d++) check_slot(0, d, 4'h9, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
